// File: rtl/gbproc_pkg.sv
// -----------------------------------------------------------------------------
// gbproc_pkg
// Shared types and constants for the gbproc accumulator core:
//   - alu_op_e    : ALU operation selected by opcode bits [5:3] of 10ooo_sss
//   - REG_*       : register-file indices as encoded in the ddd/sss fields
//   - state_e     : sequencer state (IDLE, or waiting for an LD immediate)
//   - FLAG_*      : bit positions of {Z,N,H,C} inside the 4-bit flag word
//   - GRP_*       : opcode group in bits [7:6]
// -----------------------------------------------------------------------------
package gbproc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } alu_op_e;

  // Register indices; index 6 has no storage behind it.
  localparam logic [2:0] REG_B    = 3'd0;
  localparam logic [2:0] REG_C    = 3'd1;
  localparam logic [2:0] REG_D    = 3'd2;
  localparam logic [2:0] REG_E    = 3'd3;
  localparam logic [2:0] REG_H    = 3'd4;
  localparam logic [2:0] REG_L    = 3'd5;
  localparam logic [2:0] REG_NONE = 3'd6;
  localparam logic [2:0] REG_A    = 3'd7;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_IMM = 1'b1
  } state_e;

  // Flag word layout is {Z,N,H,C}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] GRP_LD_IMM = 2'b00;
  localparam logic [1:0] GRP_MOV    = 2'b01;
  localparam logic [1:0] GRP_ALU    = 2'b10;

  // 00ddd_110 loads the following word into reg[ddd].
  function automatic logic is_ld_imm(input logic [7:0] opcode);
    return (opcode[7:6] == GRP_LD_IMM) && (opcode[2:0] == REG_NONE);
  endfunction

endpackage : gbproc_pkg

// File: rtl/gbproc_alu.sv
// -----------------------------------------------------------------------------
// gbproc_alu
// Purely combinational accumulator ALU, DATA_W bits wide.
// Ports:
//   op_i     : operation (alu_op_e)
//   a_i      : accumulator operand
//   b_i      : source operand
//   carry_i  : current C flag, consumed only by ADC/SBC
//   res_o    : operation result (for CP, the difference A - src)
//   flags_o  : {Z,N,H,C} for res_o
// H is the carry out of bit 3 (borrow into bit 4 for subtracts); C is the carry
// out of the top bit (borrow for subtracts).
// -----------------------------------------------------------------------------
module gbproc_alu
  import gbproc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] res_o,
  output logic [3:0]        flags_o
);

  logic              cin;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic [4:0]        sum_n;
  logic [4:0]        diff_n;
  logic [DATA_W-1:0] res;
  logic              flag_n;
  logic              flag_h;
  logic              flag_c;

  assign cin = ((op_i == ALU_ADC) || (op_i == ALU_SBC)) ? carry_i : 1'b0;

  // One extra bit on each path captures carry/borrow out; a subtract that
  // borrows wraps, leaving the extra bit set.
  assign sum_w  = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin};
  assign diff_w = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, cin};
  assign sum_n  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0000, cin};
  assign diff_n = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'b0000, cin};

  // NOTE: every variable written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    res    = '0;
    flag_n = 1'b0;
    flag_h = 1'b0;
    flag_c = 1'b0;
    case (op_i)
      ALU_ADD, ALU_ADC: begin
        res    = sum_w[DATA_W-1:0];
        flag_h = sum_n[4];
        flag_c = sum_w[DATA_W];
      end
      ALU_SUB, ALU_SBC, ALU_CP: begin
        res    = diff_w[DATA_W-1:0];
        flag_n = 1'b1;
        flag_h = diff_n[4];
        flag_c = diff_w[DATA_W];
      end
      ALU_AND: begin
        res    = a_i & b_i;
        flag_h = 1'b1;
      end
      ALU_XOR: res = a_i ^ b_i;
      ALU_OR:  res = a_i | b_i;
      default: res = '0;
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_Z] = (res == '0);
    flags_o[FLAG_N] = flag_n;
    flags_o[FLAG_H] = flag_h;
    flags_o[FLAG_C] = flag_c;
  end

  assign res_o = res;

endmodule : gbproc_alu

// File: rtl/gbproc_param.sv
// -----------------------------------------------------------------------------
// gbproc_param
// Small accumulator processor: register file {B,C,D,E,H,L,A}, flag register F,
// LD r,imm sequencer, ALU result buffer with valid/ready handshake and a
// retired-instruction counter.
// Ports:
//   clock, reset_n        : single rising-edge clock, async active-low reset
//   instr_data/valid/ready: instruction stream (opcode in bits [7:0])
//   res_data/flags/valid/ready : one-entry buffer holding the last ALU result
//   retired               : wrapping count of completed instructions
//   probe (optional)      : {A,B,C,D,E,F',H,L}, present only when the macro
//                           GBPROC_PROBE_EN is defined
// Opcodes: 10ooo_sss ALU A op src, 01ddd_sss MOV, 00ddd_110 LD r,imm, else NOP.
// -----------------------------------------------------------------------------
module gbproc_param
  import gbproc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   instr_data,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic [3:0]          res_flags,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_W-1:0]    retired
`ifdef GBPROC_PROBE_EN
  ,
  output logic [8*DATA_W-1:0] probe
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  logic [3:0]        flags_q, flags_d;
  state_e            state_q, state_d;
  logic [2:0]        dst_q, dst_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [3:0]        res_flags_q, res_flags_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [7:0]        opcode;
  logic [2:0]        src_idx;
  logic [2:0]        dst_idx;
  logic [DATA_W-1:0] src_val;
  logic              instr_accept;
  logic              retire;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;
  alu_op_e           alu_op;

  assign opcode       = instr_data[7:0];
  assign src_idx      = opcode[2:0];
  assign dst_idx      = opcode[5:3];
  assign alu_op       = alu_op_e'(opcode[5:3]);
  assign instr_ready  = !res_valid_q || res_ready;
  assign instr_accept = instr_valid && instr_ready;
  assign src_val      = (src_idx == REG_NONE) ? '0 : regs_q[src_idx];

  gbproc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i    (alu_op),
    .a_i     (regs_q[REG_A]),
    .b_i     (src_val),
    .carry_i (flags_q[FLAG_C]),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  function automatic logic [DATA_W-1:0] reg_reset_val(input logic [2:0] idx);
    logic [DATA_W-1:0] val;
    case (idx)
      REG_B:   val = DATA_W'(1);
      REG_C:   val = DATA_W'(2);
      REG_D:   val = DATA_W'(3);
      REG_E:   val = DATA_W'(4);
      REG_H:   val = DATA_W'(5);
      REG_L:   val = DATA_W'(6);
      REG_A:   val = '0;
      default: val = '0;
    endcase
    return val;
  endfunction

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d      = regs_q;
    flags_d     = flags_q;
    state_d     = state_q;
    dst_d       = dst_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_valid_d = res_valid_q;
    retire      = 1'b0;

    // A pop empties the buffer; an ALU op accepted in the same cycle below
    // overrides this and reloads it.
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    if (instr_accept) begin
      case (state_q)
        ST_IDLE: begin
          if (opcode[7:6] == GRP_ALU) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_res;
            res_flags_d = alu_flags;
            // CP compares only: flags follow the difference, A is kept.
            flags_d     = alu_flags;
            if (alu_op != ALU_CP) begin
              regs_d[REG_A] = alu_res;
            end
            retire = 1'b1;
          end else if (opcode[7:6] == GRP_MOV) begin
            if (dst_idx != REG_NONE) begin
              regs_d[dst_idx] = src_val;
            end
            retire = 1'b1;
          end else if (is_ld_imm(opcode)) begin
            // Retires when its immediate arrives.
            state_d = ST_WAIT_IMM;
            dst_d   = dst_idx;
          end else begin
            retire = 1'b1;
          end
        end
        ST_WAIT_IMM: begin
          if (dst_q != REG_NONE) begin
            regs_d[dst_q] = instr_data;
          end
          state_d = ST_IDLE;
          retire  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    retired_d = retired_q + CNT_W'(retire);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the register file is architecturally visible with defined reset
      // values, so it is reset like any other flop rather than left as memory.
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= reg_reset_val(3'(i));
      end
      flags_q     <= '0;
      state_q     <= ST_IDLE;
      dst_q       <= REG_NONE;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      state_q     <= state_d;
      dst_q       <= dst_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_valid_q <= res_valid_d;
      retired_q   <= retired_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign res_valid = res_valid_q;
  assign retired   = retired_q;

`ifdef GBPROC_PROBE_EN
  assign probe = {regs_q[REG_A], regs_q[REG_B], regs_q[REG_C], regs_q[REG_D],
                  regs_q[REG_E], {flags_q, {(DATA_W-4){1'b0}}},
                  regs_q[REG_H], regs_q[REG_L]};
`endif

endmodule : gbproc_param

// File: doc/gbproc_param.md
GBPROC_PARAM -- requirements
Module: gbproc_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath and register width in bits (legal: 8..32).
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have port clock  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port instr_data  in  DATA_W  instruction word; opcode in bits [7:0]; immediate uses all DATA_W bits.
REQ-006 SHALL have port instr_valid  in  1  instr_data valid.
REQ-007 SHALL have port instr_ready  out  1  block accepts instr_data this cycle.
REQ-008 SHALL have port res_data  out  DATA_W  last ALU result.
REQ-009 SHALL have port res_flags  out  4  {Z,N,H,C} of that result.
REQ-010 SHALL have port res_valid  out  1  result buffer full.
REQ-011 SHALL have port res_ready  in  1  consumer takes result.
REQ-012 SHALL have port retired  out  CNT_W  count of completed instructions.

Function
REQ-013 SHALL transfer an instruction word only on clock edges with instr_valid & instr_ready.
REQ-014 SHALL drive instr_ready = !res_valid | res_ready.
REQ-015 SHALL decode register index r: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 none (reads 0, writes dropped), 7 A.
REQ-016 SHALL execute opcode 10ooo_sss as A op src: ADD, ADC, SUB, SBC, AND, XOR, OR, CP for ooo = 0..7.
REQ-017 SHALL not update A on CP; all other ALU ops SHALL update A and the 4-bit flag register F.
REQ-018 SHALL set flags as follows: Z = result==0; N=1 for SUB/SBC/CP; H = carry out of bit 3 (borrow into bit 4 for subtract); C = carry out of bit DATA_W-1 (borrow for subtract).
REQ-019 SHALL use C as carry-in for ADC/SBC; AND SHALL give H=1, C=0; XOR/OR SHALL give H=0, C=0.
REQ-020 SHALL load res_data/res_flags and set res_valid one cycle after an ALU op is accepted (CP included).
REQ-021 SHALL clear res_valid on res_ready & res_valid unless a new ALU op is accepted in the same cycle, in which case the buffer reloads and res_valid stays 1.
REQ-022 SHALL execute opcode 01ddd_sss as reg[ddd] <= reg[sss], leaving flags unchanged.
REQ-023 SHALL treat opcode 00ddd_110 as LD r,imm: move FSM IDLE->WAIT_IMM; the next accepted word is the immediate, written to reg[ddd]; WAIT_IMM->IDLE.
REQ-024 SHALL treat all other opcodes as NOP.
REQ-025 SHALL increment retired once per completed instruction (LD counts at its immediate); the counter SHALL wrap from all-ones to 0.
REQ-026 SHALL make register writes visible to the instruction accepted in the next cycle (no stall between back-to-back dependent instructions).

Reset
REQ-027 SHALL, while reset_n=0, set A=0, B=1, C=2, D=3, E=4, H=5, L=6, F=0, FSM=IDLE, res_valid=0, res_data=0, res_flags=0, retired=0; instr_ready=1 after release.
REQ-028 SHALL abort a pending LD when reset asserts in WAIT_IMM; no register is written.

Configuration
REQ-029 SHALL, with macro GBPROC_PROBE_EN defined, add output probe [8*DATA_W] = {A,B,C,D,E,F',H,L}, where F' = {F, 0s} left-aligned in DATA_W.
REQ-030 SHALL, without GBPROC_PROBE_EN, omit the probe port; all other behaviour is identical.

Structure
REQ-031 SHALL place the ALU-op enum, register-index constants, the FSM state enum and the flag bit positions in package gbproc_pkg.
REQ-032 SHALL implement the arithmetic as sub-module gbproc_alu (combinational, parametrised on DATA_W); the sequencing, registers and result buffer SHALL be in gbproc_param.

Verification (DATA_W=8)
REQ-033 SHALL check: reset, then 0x80 (ADD A,B) -> A=0x01, res_data=0x01, res_flags=0000, res_valid=1 one cycle later.
REQ-034 SHALL check: 0x3E,0xFF (LD A,0xFF), then 0x80 -> A=0x00, flags Z=1 H=1 C=1, retired=2.
REQ-035 SHALL check: 0x97 (SUB A,A) -> A=0x00, Z=1 N=1 H=0 C=0; then 0xBF (CP A) -> A unchanged, Z=1 N=1.
REQ-036 SHALL check: res_ready=0 with two ALU ops offered -> first accepted, instr_ready=0, second held; raising res_ready with the second valid -> pop and reload in the same cycle, res_valid stays 1.
REQ-037 SHALL check: 0x0E accepted, reset_n pulsed low, then 0x55 -> 0x55 is decoded as an opcode (MOV D,L; D=0x06), and C=0x02.
REQ-038 SHALL check: 0x41 (MOV B,C), then 0x80 next cycle -> A=0x02; retired wraps to 0 after 65536 NOPs.
